wb_mdio_master: RTL and testbench
=================================

Name: wb_mdio_master

Overview:
- Wishbone classic slave holding the MAC management (MII) register set, plus the MDIO/MDC serial engine that runs IEEE 802.3 clause-22 frames to the external PHY.
- Acts as the responder to the board bring-up Wishbone master, which programs the clock divider, selects PHY and register, issues read/write commands, polls busy, then reads the result.
- Sits between the bring-up/config master and the PHY MDIO pins, in the same clock domain as that master.

Parameters:
- DIV_RESET, 8'd64, MDC divider value after reset.
- PREAMBLE_LEN, 32, number of leading '1' bits per frame (0 disables the preamble).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- wb_stb  in  1  Wishbone strobe
- wb_cyc  in  1  Wishbone cycle
- wb_we  in  1  write enable
- wb_adr  in  8  byte address; bits [7:2] select the word, bits [1:0] are ignored
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack  out  1  single-cycle acknowledge
- mdc  out  1  management clock to the PHY
- mdio_o  out  1  MDIO output data
- mdio_oe  out  1  MDIO output enable (1 = drive the pin)
- mdio_i  in  1  MDIO input from the pad

Behaviour:
- Reset: clk and reset as already decided; reset is synchronous, active-high, on clk. On reset: wb_ack=0, wb_dat_o=0, mdc=0, mdio_o=1, mdio_oe=0, busy=0, clkdiv=DIV_RESET, and all other registers cleared. Reset mid-frame aborts the frame immediately; no partial data is stored.
- Register map (word index):
  - 5 CLKDIV [7:0], R/W.
  - 6 MIIADDRESS: PHYAD [4:0], REGAD [12:8], R/W.
  - 7 MIITX_DATA [15:0], R/W.
  - 8 MIICOMMAND, write-only; reads return 0. Bit2 = WCTRL (write frame), bit1 = RSTAT (read frame). If both bits are set, WCTRL takes precedence. Other bits are ignored.
  - 9 MIISTATUS, read-only: bit1 busy, bit2 rx_valid.
  - 10 MIIRX_DATA [15:0], read-only.
  - Unmapped words read 0; writes to them are dropped.
- Wishbone handshake:
  - wb_ack rises the cycle after stb&cyc is sampled with ack low, lasts exactly 1 cycle, then stays low for at least 1 cycle. Back-to-back access therefore takes 2 cycles.
  - The write takes effect on the same edge that raises wb_ack.
  - wb_dat_o is registered every cycle from the current wb_adr, regardless of stb/cyc, with 1-cycle latency. This supports polling MIISTATUS by address alone.
- Command start:
  - A MIICOMMAND write with busy=0 and WCTRL or RSTAT set latches PHYAD, REGAD, TX data and the opcode, sets busy=1 on the same edge, and clears rx_valid.
  - A MIICOMMAND write while busy=1 is acked and ignored.
  - Writes to MIIADDRESS or MIITX_DATA while busy are accepted but do not affect the in-flight frame.
- MDC generation:
  - half = max(clkdiv[7:1],1), so the MDC period is 2*half clk cycles. Example: div 24 at 150 MHz gives 6.25 MHz.
  - mdc is held low and the divider counter is held at 0 while idle.
  - A CLKDIV write during a frame takes effect at the next frame start.
- FSM: IDLE -> PRE (PREAMBLE_LEN bits of 1) -> ST (01) -> OP (01 write / 10 read) -> PHY (5 bits, MSB first) -> REG (5 bits) -> TA -> DATA (16 bits) -> DONE -> IDLE.
  - TA on write: drive 10. TA on read: mdio_oe=0 for both TA bits.
  - Output bits change 1 clk after the mdc falling edge; the first bit is presented before the first rising edge. Input is sampled on the clk where mdc rises.
  - Read DATA: mdio_oe=0, shift mdio_i MSB first.
  - DONE: mdc=0, mdio_oe=0, mdio_o=1. For a read, MIIRX_DATA is updated and rx_valid=1. busy=0 on the following cycle.
  - Frame length is PREAMBLE_LEN+32 MDC periods.
- mdio_oe stays 0 whenever the FSM is idle.

Decomposition:
- Shared package: register word indices (5..10), command bit positions, status bit positions, MDIO opcodes, ST/TA constants.
- One sub-module, mdio_shifter: MDC divider plus bit-level frame FSM, with start/op/phy/reg/wdata inputs and busy/rdata/done outputs. The top level holds the Wishbone decoding and the registers.

Test Plan:
- Reset then read word 5 -> wb_dat_o=64. Read word 9 -> 0. Check mdio_oe=0 and mdc=0.
- Write CLKDIV=24, ADDRESS=0x1B07, TXDATA=0xABCF, COMMAND=4 -> busy=1 the next cycle. On pins: 32 ones, 01, 01, 00111, 11011, 10, 0xABCF MSB first. MDC period is 24 clk. busy clears after 64 MDC periods.
- ADDRESS=0x0107, COMMAND=2, PHY model returns 0x796D on mdio_i -> mdio_oe=0 from TA through DATA. MIIRX_DATA=0x796D and status bit2=1 after busy drops.
- Issue COMMAND=4 while busy -> ack pulse observed, frame unchanged, no second frame starts.
- Assert reset at the midpoint of a read frame -> the next cycle shows mdc=0, mdio_oe=0, busy=0, rx_valid=0, and MIIRX_DATA unchanged at 0.
- Hold stb&cyc for 5 cycles -> wb_ack high on cycles 2 and 4 only. CLKDIV=1 -> MDC period is 2 clk.

Source files
------------

// File: rtl/wb_mdio_master_pkg.sv
// Shared constants for the Wishbone MII management block: register map,
// command/status bit positions, MDIO frame fields and the frame FSM states.
package wb_mdio_master_pkg;

    localparam logic [5:0] W_CLKDIV  = 6'd5;
    localparam logic [5:0] W_ADDRESS = 6'd6;
    localparam logic [5:0] W_TXDATA  = 6'd7;
    localparam logic [5:0] W_COMMAND = 6'd8;
    localparam logic [5:0] W_STATUS  = 6'd9;
    localparam logic [5:0] W_RXDATA  = 6'd10;

    localparam int CMD_RSTAT    = 1;
    localparam int CMD_WCTRL    = 2;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_RXVALID = 2;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] MDIO_ST  = 2'b01;
    localparam logic [1:0] MDIO_TA  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_START,
        S_OP,
        S_PHY,
        S_REG,
        S_TA,
        S_DATA,
        S_DONE
    } mdio_state_e;

    // MDC half period in clk cycles; a divider of 0 or 1 still gives a 2-cycle MDC.
    function automatic logic [6:0] mdc_half(input logic [6:0] div_hi);
        return (div_hi == 7'd0) ? 7'd1 : div_hi;
    endfunction

endpackage

// File: rtl/wb_mdio_master_shifter.sv
// MDC divider and clause-22 bit-level frame engine. One frame per start pulse;
// operands are latched at start so register writes during a frame do not disturb it.
//
// state   | meaning
// S_IDLE  | mdc low, pin released, waiting for start
// S_PRE   | preamble ones
// S_START | start-of-frame 01
// S_OP    | opcode (01 write, 10 read)
// S_PHY   | PHY address, MSB first
// S_REG   | register address, MSB first
// S_TA    | turnaround: drive 10 on write, release on read
// S_DATA  | 16 data bits, driven on write, sampled on read
// S_DONE  | one-cycle completion, rdata valid
module wb_mdio_master_shifter
    import wb_mdio_master_pkg::*;
#(
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [4:0]  phy_i,
    input  logic [4:0]  reg_i,
    input  logic [15:0] wdata_i,
    input  logic [6:0]  half_i,
    input  logic        mdio_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] rdata_o,
    output logic        mdc_o,
    output logic        mdo_o,
    output logic        mdoe_o
);

    localparam int CNT_W = (PREAMBLE_LEN > 16) ? $clog2(PREAMBLE_LEN) : 4;

    mdio_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         div_cnt_q;
    logic [6:0]         half_q;
    logic               mdc_q;
    logic               adv_q;
    logic [1:0]         op_q;
    logic [4:0]         phy_q;
    logic [4:0]         reg_q;
    logic [15:0]        wdata_q;
    logic [15:0]        rx_sh_q;
    logic               start_go;
    logic               running;
    logic               sample_en;

    assign start_go  = start_i && (state_q == S_IDLE);
    assign running   = (state_d != S_IDLE) && (state_d != S_DONE);
    // state_d is used so that with a 2-cycle MDC the bit entered on this edge is the one sampled
    assign sample_en = (state_d == S_DATA) && (op_q == OP_READ);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (PREAMBLE_LEN > 0) begin
                        state_d = S_PRE;
                        cnt_d   = CNT_W'(PREAMBLE_LEN - 1);
                    end else begin
                        state_d = S_START;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                if (adv_q) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        case (state_q)
                            S_PRE:   begin state_d = S_START; cnt_d = CNT_W'(1);  end
                            S_START: begin state_d = S_OP;    cnt_d = CNT_W'(1);  end
                            S_OP:    begin state_d = S_PHY;   cnt_d = CNT_W'(4);  end
                            S_PHY:   begin state_d = S_REG;   cnt_d = CNT_W'(4);  end
                            S_REG:   begin state_d = S_TA;    cnt_d = CNT_W'(1);  end
                            S_TA:    begin state_d = S_DATA;  cnt_d = CNT_W'(15); end
                            default: begin state_d = S_DONE;  cnt_d = '0;         end
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        mdo_o  = 1'b1;
        mdoe_o = 1'b0;
        case (state_q)
            S_PRE:   begin mdoe_o = 1'b1; mdo_o = 1'b1; end
            S_START: begin mdoe_o = 1'b1; mdo_o = MDIO_ST[cnt_q[0]]; end
            S_OP:    begin mdoe_o = 1'b1; mdo_o = op_q[cnt_q[0]]; end
            S_PHY:   begin mdoe_o = 1'b1; mdo_o = phy_q[cnt_q[2:0]]; end
            S_REG:   begin mdoe_o = 1'b1; mdo_o = reg_q[cnt_q[2:0]]; end
            S_TA: begin
                if (op_q == OP_WRITE) begin
                    mdoe_o = 1'b1;
                    mdo_o  = MDIO_TA[cnt_q[0]];
                end
            end
            S_DATA: begin
                if (op_q == OP_WRITE) begin
                    mdoe_o = 1'b1;
                    mdo_o  = wdata_q[cnt_q[3:0]];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_cnt_q <= '0;
            half_q    <= 7'd1;
            mdc_q     <= 1'b0;
            adv_q     <= 1'b0;
            op_q      <= '0;
            phy_q     <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            rx_sh_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adv_q   <= 1'b0;
            if (start_go) begin
                op_q      <= op_i;
                phy_q     <= phy_i;
                reg_q     <= reg_i;
                wdata_q   <= wdata_i;
                half_q    <= half_i;
                div_cnt_q <= half_i - 7'd1;
                mdc_q     <= 1'b0;
                rx_sh_q   <= '0;
            end else if (!running) begin
                div_cnt_q <= '0;
                mdc_q     <= 1'b0;
            end else if (div_cnt_q == '0) begin
                div_cnt_q <= half_q - 7'd1;
                mdc_q     <= ~mdc_q;
                // a falling MDC edge schedules the bit advance for the next clk
                adv_q     <= mdc_q;
                if (!mdc_q && sample_en) begin
                    rx_sh_q <= {rx_sh_q[14:0], mdio_i};
                end
            end else begin
                div_cnt_q <= div_cnt_q - 7'd1;
            end
        end
    end

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);
    assign rdata_o = rx_sh_q;
    assign mdc_o   = mdc_q;

endmodule

// File: rtl/wb_mdio_master.sv
// Wishbone classic slave holding the MII management registers; drives the
// MDIO frame engine and captures read results.
module wb_mdio_master
    import wb_mdio_master_pkg::*;
#(
    parameter logic [7:0] DIV_RESET    = 8'd64,
    parameter int         PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_stb,
    input  logic        wb_cyc,
    input  logic        wb_we,
    input  logic [7:0]  wb_adr,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  clkdiv_q;
    logic [4:0]  phyad_q;
    logic [4:0]  regad_q;
    logic [15:0] txdata_q;
    logic [15:0] rxdata_q;
    logic        rx_valid_q;
    logic        rd_op_q;

    logic [5:0]  word;
    logic        wr;
    logic        wctrl;
    logic        rstat;
    logic        start;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic        unused_bits;

    assign word  = wb_adr[7:2];
    assign ack_d = wb_stb && wb_cyc && !ack_q;
    assign wr    = ack_d && wb_we;
    assign wctrl = wb_dat_i[CMD_WCTRL];
    assign rstat = wb_dat_i[CMD_RSTAT];
    assign start = wr && (word == W_COMMAND) && !busy && (wctrl || rstat);
    assign op    = wctrl ? OP_WRITE : OP_READ;

    assign unused_bits = ^{wb_adr[1:0], wb_dat_i[31:16]};

    always_comb begin
        dat_d = '0;
        case (word)
            W_CLKDIV:  dat_d[7:0] = clkdiv_q;
            W_ADDRESS: begin
                dat_d[4:0]  = phyad_q;
                dat_d[12:8] = regad_q;
            end
            W_TXDATA:  dat_d[15:0] = txdata_q;
            W_STATUS: begin
                dat_d[STAT_BUSY]    = busy;
                dat_d[STAT_RXVALID] = rx_valid_q;
            end
            W_RXDATA:  dat_d[15:0] = rxdata_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            clkdiv_q   <= DIV_RESET;
            phyad_q    <= '0;
            regad_q    <= '0;
            txdata_q   <= '0;
            rxdata_q   <= '0;
            rx_valid_q <= 1'b0;
            rd_op_q    <= 1'b0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            if (wr) begin
                case (word)
                    W_CLKDIV:  clkdiv_q <= wb_dat_i[7:0];
                    W_ADDRESS: begin
                        phyad_q <= wb_dat_i[4:0];
                        regad_q <= wb_dat_i[12:8];
                    end
                    W_TXDATA:  txdata_q <= wb_dat_i[15:0];
                    default: ;
                endcase
            end
            if (start) begin
                rx_valid_q <= 1'b0;
                rd_op_q    <= !wctrl;
            end else if (done && rd_op_q) begin
                rxdata_q   <= rdata;
                rx_valid_q <= 1'b1;
            end
        end
    end

    wb_mdio_master_shifter #(
        .PREAMBLE_LEN(PREAMBLE_LEN)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .op_i    (op),
        .phy_i   (phyad_q),
        .reg_i   (regad_q),
        .wdata_i (txdata_q),
        .half_i  (mdc_half(clkdiv_q[7:1])),
        .mdio_i  (mdio_i),
        .busy_o  (busy),
        .done_o  (done),
        .rdata_o (rdata),
        .mdc_o   (mdc),
        .mdo_o   (mdio_o),
        .mdoe_o  (mdio_oe)
    );

    assign wb_ack   = ack_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_mdio_master.sv
// Self-checking bench for wb_mdio_master: register access, Wishbone handshake,
// clause-22 frames on the pins via a bit scoreboard, and a PHY read model.
module tb_wb_mdio_master;

    localparam int PRE = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_stb = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_we = 1'b0;
    logic [7:0]  wb_adr = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i = 1'b1;

    wb_mdio_master #(
        .DIV_RESET    (8'd64),
        .PREAMBLE_LEN (PRE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_stb   (wb_stb),
        .wb_cyc   (wb_cyc),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack   (wb_ack),
        .mdc      (mdc),
        .mdio_o   (mdio_o),
        .mdio_oe  (mdio_oe),
        .mdio_i   (mdio_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic oe;
        logic o;
        logic chk_o;
    } exp_bit_t;

    exp_bit_t    exp_q[$];
    logic [15:0] rx_exp_q[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rise_cnt = 0;
    int          frame_base = 0;
    int          last_rise = 0;
    int          exp_per = 24;
    logic [15:0] phy_rd = '0;
    logic        mdc_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic phy_bit(input int n);
        if (n >= PRE + 16 && n < PRE + 32) return phy_rd[15 - (n - PRE - 16)];
        return 1'b1;
    endfunction

    // Pin monitor and PHY model: every MDC rise pops one expected bit.
    always @(negedge clk) begin
        exp_bit_t e;
        int       pos;
        if (mdc && !mdc_prev) begin
            pos = rise_cnt - frame_base;
            if (pos != 0) chk("mdc_period", cyc - last_rise, exp_per);
            if (exp_q.size() == 0) begin
                chk("extra_bit", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("mdio_oe", mdio_oe, e.oe);
                if (e.chk_o) chk("mdio_o", mdio_o, e.o);
            end
            last_rise = cyc;
            rise_cnt++;
            mdio_i = phy_bit(rise_cnt - frame_base);
        end
        mdc_prev = mdc;
    end

    task automatic push_bit(input logic oe, input logic o, input logic c);
        exp_bit_t e;
        e.oe = oe;
        e.o = o;
        e.chk_o = c;
        exp_q.push_back(e);
    endtask

    task automatic start_frame(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                               input logic [15:0] d);
        frame_base = rise_cnt;
        mdio_i = 1'b1;
        for (int i = 0; i < PRE; i++) push_bit(1, 1, 1);
        push_bit(1, 0, 1);
        push_bit(1, 1, 1);
        push_bit(1, !wr, 1);
        push_bit(1, wr, 1);
        for (int i = 4; i >= 0; i--) push_bit(1, phy[i], 1);
        for (int i = 4; i >= 0; i--) push_bit(1, rg[i], 1);
        if (wr) begin
            push_bit(1, 1, 1);
            push_bit(1, 0, 1);
        end else begin
            push_bit(0, 0, 0);
            push_bit(0, 0, 0);
        end
        for (int i = 15; i >= 0; i--) begin
            if (wr) push_bit(1, d[i], 1);
            else    push_bit(0, 0, 0);
        end
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        wb_adr = a; wb_dat_i = d; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wb_ack", wb_ack, 1);
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        wb_adr = a; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d = wb_dat_o;
        wb_stb = 1'b0; wb_cyc = 1'b0;
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int n;
        s = 32'h2;
        n = 0;
        while (s[1] && n < 3000) begin
            wb_read(8'(9 << 2), s);
            n++;
        end
        chk("busy_timeout", s[1], 0);
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 20000 && (rise_cnt - frame_base) < p; i++) @(negedge clk);
        chk("pos_reached", (rise_cnt - frame_base) >= p, 1);
    endtask

    initial begin
        logic [31:0] d;
        int r0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack", wb_ack, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_mdc", mdc, 0);
        chk("rst_oe", mdio_oe, 0);
        chk("rst_mdo", mdio_o, 1);
        reset = 1'b0;
        wb_read(8'(5 << 2), d);  chk("clkdiv_rst", d, 64);
        wb_read(8'(9 << 2), d);  chk("status_rst", d, 0);
        wb_read(8'(12 << 2), d); chk("unmapped_rd", d, 0);

        // write frame at divider 24
        wb_write(8'(5 << 2), 24);
        wb_write(8'(6 << 2), 32'h1B07);
        wb_write(8'(7 << 2), 32'hABCF);
        wb_read(8'(6 << 2), d);  chk("addr_rb", d, 32'h1B07);
        wb_read(8'(8 << 2), d);  chk("cmd_rd0", d, 0);
        exp_per = 24;
        start_frame(1, 5'h07, 5'h1B, 16'hABCF);
        wb_write(8'(8 << 2), 4);
        wb_read(8'(9 << 2), d);  chk("busy_set", d, 2);
        wait_idle();
        chk("wr_rises", rise_cnt - frame_base, 64);
        chk("wr_bits_left", exp_q.size(), 0);
        chk("idle_oe", mdio_oe, 0);
        chk("idle_mdc", mdc, 0);

        // read frame; a command issued mid-frame must be ignored
        wb_write(8'(6 << 2), 32'h0107);
        phy_rd = 16'h796D;
        start_frame(0, 5'h07, 5'h01, 16'h0);
        rx_exp_q.push_back(16'h796D);
        wb_write(8'(8 << 2), 2);
        wait_pos(20);
        wb_write(8'(8 << 2), 4);
        wait_idle();
        chk("rd_rises", rise_cnt - frame_base, 64);
        chk("rd_bits_left", exp_q.size(), 0);
        wb_read(8'(10 << 2), d);
        chk("rx_data", d, {16'h0, rx_exp_q.pop_front()});
        wb_read(8'(9 << 2), d);  chk("rx_valid", d, 4);
        r0 = rise_cnt;
        repeat (200) @(negedge clk);
        chk("no_second_frame", rise_cnt - r0, 0);

        // ack with strobe held for 5 cycles
        @(negedge clk);
        wb_adr = 8'(9 << 2); wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk("ack_hold", wb_ack, (k == 2 || k == 4) ? 1 : 0);
            if (k < 5) @(negedge clk);
        end
        wb_stb = 1'b0; wb_cyc = 1'b0;
        repeat (2) @(negedge clk);
        chk("ack_after", wb_ack, 0);

        // divider 1: 2-cycle MDC, both bits set selects write
        wb_write(8'(5 << 2), 1);
        wb_write(8'(6 << 2), 32'h0A15);
        wb_write(8'(7 << 2), 32'h5A3C);
        exp_per = 2;
        start_frame(1, 5'h15, 5'h0A, 16'h5A3C);
        wb_write(8'(8 << 2), 6);
        wait_idle();
        chk("fast_wr_rises", rise_cnt - frame_base, 64);
        chk("fast_wr_left", exp_q.size(), 0);
        phy_rd = 16'hC3A5;
        start_frame(0, 5'h15, 5'h0A, 16'h0);
        rx_exp_q.push_back(16'hC3A5);
        wb_write(8'(8 << 2), 2);
        wait_idle();
        chk("fast_rd_left", exp_q.size(), 0);
        wb_read(8'(10 << 2), d);
        chk("fast_rx_data", d, {16'h0, rx_exp_q.pop_front()});

        // reset in the middle of a read frame
        phy_rd = 16'h1234;
        start_frame(0, 5'h15, 5'h0A, 16'h0);
        wb_write(8'(8 << 2), 2);
        wait_pos(32);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_mdc", mdc, 0);
        chk("midrst_oe", mdio_oe, 0);
        exp_q.delete();
        reset = 1'b0;
        wb_read(8'(9 << 2), d);  chk("midrst_status", d, 0);
        wb_read(8'(10 << 2), d); chk("midrst_rx", d, 0);
        wb_read(8'(5 << 2), d);  chk("midrst_clkdiv", d, 64);
        r0 = rise_cnt;
        repeat (50) @(negedge clk);
        chk("midrst_no_mdc", rise_cnt - r0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
